// File: rtl/cmd_receiver_pkg.sv
// Command-format constants and FSM state types shared by the SUMP command receiver.
package cmd_receiver_pkg;

  localparam int unsigned CMD_WIDTH      = 40;
  localparam int unsigned OPCODE_WIDTH   = 8;
  localparam int unsigned DATA_WIDTH     = CMD_WIDTH - OPCODE_WIDTH;
  localparam int unsigned LONG_CMD_BIT   = 7;
  localparam int unsigned LONG_ARG_BYTES = 4;

  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP
  } bit_state_e;

  typedef enum logic {
    CMD_OPCODE,
    CMD_ARGS
  } cmd_state_e;

endpackage

// File: rtl/cmd_receiver_uart_rx.sv
// 8N1 UART byte receiver: 2-flop synchroniser, start-edge detect, mid-bit sampling.
module uart_rx_byte
  import cmd_receiver_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 100000000,
  parameter int unsigned BAUD       = 115200
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rx_i,
  output logic [OPCODE_WIDTH-1:0] byte_o,
  output logic                    byte_valid_o,
  output logic                    framing_error_o,
  output logic                    idle_o
);

  localparam int unsigned BIT_CYCLES = CLOCK_FREQ / BAUD;
  localparam int unsigned CNT_W      = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(BIT_CYCLES - 1);

  logic [1:0]              sync_q;
  logic                    rx_prev_q;
  bit_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [OPCODE_WIDTH-1:0] shift_q, shift_d;
  logic                    rx_s;

  assign rx_s   = sync_q[1];
  assign byte_o = shift_q;
  assign idle_o = (state_q == BIT_IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      state_q   <= BIT_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    byte_valid_o    = 1'b0;
    framing_error_o = 1'b0;
    case (state_q)
      BIT_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = BIT_START;
          cnt_d   = HALF_RELOAD;
        end
      end
      BIT_START: begin
        // Re-check the line at mid start bit; a high level means the edge was a glitch.
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_d = BIT_IDLE;
          end else begin
            state_d   = BIT_DATA;
            cnt_d     = FULL_RELOAD;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      BIT_DATA: begin
        if (cnt_q == '0) begin
          shift_d   = {rx_s, shift_q[OPCODE_WIDTH-1:1]};
          cnt_d     = FULL_RELOAD;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = BIT_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      BIT_STOP: begin
        if (cnt_q == '0) begin
          state_d = BIT_IDLE;
          if (rx_s) byte_valid_o    = 1'b1;
          else      framing_error_o = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = BIT_IDLE;
    endcase
  end

endmodule

// File: rtl/cmd_receiver.sv
// SUMP command front end: assembles 1-byte short and 5-byte long commands from the UART.
module cmd_receiver
  import cmd_receiver_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ   = 100000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [CMD_WIDTH-1:0] cmd,
  output logic                 execute,
  output logic                 framingError,
  output logic                 rxActive
);

  localparam int unsigned BIT_CYCLES     = CLOCK_FREQ / BAUD;
  localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_BITS * BIT_CYCLES;
  localparam int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IDX_W          = $clog2(LONG_ARG_BYTES);

  logic [OPCODE_WIDTH-1:0] rx_byte;
  logic                    byte_valid;
  logic                    frame_err;
  logic                    bit_idle;

  cmd_state_e              state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CMD_WIDTH-1:0]    cmd_q, cmd_d;
  logic                    execute_q, execute_d;
  logic                    framing_q;
  logic [TO_W-1:0]         idle_cnt_q, idle_cnt_d;
  logic                    timeout;

  uart_rx_byte #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD      (BAUD)
  ) u_rx (
    .clk_i          (clock),
    .rst_ni         (reset_n),
    .rx_i           (rx),
    .byte_o         (rx_byte),
    .byte_valid_o   (byte_valid),
    .framing_error_o(frame_err),
    .idle_o         (bit_idle)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= CMD_OPCODE;
      opcode_q   <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      cmd_q      <= '0;
      execute_q  <= 1'b0;
      framing_q  <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      cmd_q      <= cmd_d;
      execute_q  <= execute_d;
      framing_q  <= frame_err;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Idle counter only advances between bytes of a long command; any active byte clears it.
  always_comb begin
    timeout    = 1'b0;
    idle_cnt_d = '0;
    if (state_q == CMD_ARGS && bit_idle) begin
      if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
      else                                          idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    data_d    = data_q;
    idx_d     = idx_q;
    cmd_d     = cmd_q;
    execute_d = 1'b0;
    case (state_q)
      CMD_OPCODE: begin
        if (byte_valid) begin
          opcode_d = rx_byte;
          if (rx_byte[LONG_CMD_BIT]) begin
            state_d = CMD_ARGS;
            idx_d   = '0;
          end else begin
            execute_d = 1'b1;
            cmd_d     = {{DATA_WIDTH{1'b0}}, rx_byte};
          end
        end
      end
      CMD_ARGS: begin
        // Arguments shift in from the top, so after four bytes the first lands in data[7:0].
        if (frame_err || timeout) begin
          state_d = CMD_OPCODE;
        end else if (byte_valid) begin
          data_d = {rx_byte, data_q[DATA_WIDTH-1:OPCODE_WIDTH]};
          idx_d  = idx_q + 1'b1;
          if (idx_q == IDX_W'(LONG_ARG_BYTES - 1)) begin
            state_d   = CMD_OPCODE;
            execute_d = 1'b1;
            cmd_d     = {rx_byte, data_q[DATA_WIDTH-1:OPCODE_WIDTH], opcode_q};
          end
        end
      end
      default: state_d = CMD_OPCODE;
    endcase
  end

  assign cmd          = cmd_q;
  assign execute      = execute_q;
  assign framingError = framing_q;
  assign rxActive     = !bit_idle || (state_q == CMD_ARGS);

endmodule

// File: tb/tb_cmd_receiver.sv
// Randomised UART command stream checked against a byte-queue model of SUMP framing.
module tb_cmd_receiver;

  localparam int unsigned CLK_F   = 1600;
  localparam int unsigned BAUD_R  = 100;
  localparam int unsigned TO_BITS = 4;
  localparam int unsigned BITC    = CLK_F / BAUD_R;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx      = 1'b1;
  logic [39:0] cmd;
  logic        execute;
  logic        framingError;
  logic        rxActive;

  cmd_receiver #(
    .CLOCK_FREQ  (CLK_F),
    .BAUD        (BAUD_R),
    .TIMEOUT_BITS(TO_BITS)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx          (rx),
    .cmd         (cmd),
    .execute     (execute),
    .framingError(framingError),
    .rxActive    (rxActive)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed execute/framing events
  logic [39:0] obs_cmd[$];
  int          obs_cyc[$];
  int          fe_seen      = 0;
  bit          in_reset_chk = 1'b0;

  always @(negedge clock) begin
    if (execute) begin
      obs_cmd.push_back(cmd);
      obs_cyc.push_back(cyc);
    end
    if (framingError) fe_seen++;
    if (in_reset_chk) begin
      check("rst_cmd", cmd, 64'h0);
      check("rst_exec", 64'(execute), 64'h0);
      check("rst_active", 64'(rxActive), 64'h0);
    end
  end

  // Reference model: pending bytes of a frame; commands emitted when a frame is complete
  logic [7:0]  pend[$];
  logic [39:0] exp_cmd[$];
  int          exp_lo[$];
  int          fe_exp   = 0;
  logic [39:0] last_cmd = '0;

  task automatic model_emit(input logic [39:0] c, input int stop_cyc);
    exp_cmd.push_back(c);
    exp_lo.push_back(stop_cyc + 4);
    last_cmd = c;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok, input int stop_cyc);
    if (!ok) begin
      fe_exp++;
      pend.delete();
    end else if (pend.size() == 0 && !b[7]) begin
      model_emit({32'h0, b}, stop_cyc);
    end else begin
      pend.push_back(b);
      if (pend.size() == 5) begin
        model_emit({pend[4], pend[3], pend[2], pend[1], pend[0]}, stop_cyc);
        pend.delete();
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    int stop_cyc;
    rx = 1'b0;
    repeat (BITC) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BITC) tick();
    end
    stop_cyc = cyc;
    rx = ok;
    repeat (BITC) tick();
    if (!ok) begin
      rx = 1'b1;
      repeat (BITC) tick();
    end
    model_byte(b, ok, stop_cyc);
  endtask

  // Gaps are kept either well below or well above the 64-cycle timeout
  task automatic idle_gap(input int n);
    rx = 1'b1;
    repeat (n) tick();
    if (n >= 70) pend.delete();
  endtask

  task automatic settle_and_compare(input string tag);
    logic [39:0] oc;
    int          ot;
    int          lo;
    rx = 1'b1;
    repeat (24) tick();
    check({tag, "_n"}, 64'(obs_cmd.size()), 64'(exp_cmd.size()));
    while (obs_cmd.size() > 0 && exp_cmd.size() > 0) begin
      oc = obs_cmd.pop_front();
      ot = obs_cyc.pop_front();
      lo = exp_lo.pop_front();
      check({tag, "_cmd"}, 64'(oc), 64'(exp_cmd.pop_front()));
      check({tag, "_lat"}, 64'(ot >= lo && ot <= lo + 14), 64'h1);
    end
    obs_cmd.delete();
    obs_cyc.delete();
    exp_cmd.delete();
    exp_lo.delete();
    check({tag, "_fe"}, 64'(fe_seen), 64'(fe_exp));
    check({tag, "_act"}, 64'(rxActive), 64'(pend.size() != 0));
    check({tag, "_hold"}, 64'(cmd), 64'(last_cmd));
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) tick();
    reset_n = 1'b1;
    pend.delete();
    last_cmd = '0;
  endtask

  initial begin
    int          gsel;
    logic [7:0]  b;
    bit          ok;

    // Reset with a toggling line
    reset_n = 1'b0;
    rx = 1'b1;
    tick();
    in_reset_chk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx = ~rx;
      tick();
    end
    in_reset_chk = 1'b0;
    rx = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    idle_gap(20);
    send_byte(8'h55, 1'b1);
    settle_and_compare("reset");

    send_byte(8'h01, 1'b1);
    settle_and_compare("short");

    send_byte(8'h80, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    settle_and_compare("long");

    send_byte(8'hC0, 1'b1);
    send_byte(8'h11, 1'b0);
    idle_gap(16);
    send_byte(8'h02, 1'b1);
    settle_and_compare("frame");

    send_byte(8'h81, 1'b1);
    send_byte(8'hAA, 1'b1);
    idle_gap(80);
    send_byte(8'h00, 1'b1);
    settle_and_compare("timeout");

    rx = 1'b0;
    repeat (4) tick();
    idle_gap(30);
    settle_and_compare("glitch");

    send_byte(8'h80, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    do_reset(2);
    idle_gap(20);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    settle_and_compare("midrst");

    for (int it = 0; it < 64; it++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 9) != 0);
      send_byte(b, ok);
      gsel = int'($urandom_range(0, 99));
      if (gsel < 50)      idle_gap(0);
      else if (gsel < 85) idle_gap(int'($urandom_range(1, 20)));
      else                idle_gap(int'($urandom_range(80, 100)));
      if (it % 8 == 7) settle_and_compare("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cmd_receiver.md
Name: cmd_receiver

Overview:
- Front-end stage directly upstream of the analyzer core.
- Deserialises the host UART line (8N1) and assembles SUMP command frames.
- Presents each completed frame as a 40-bit cmd word with a one-cycle execute strobe, consumed unchanged by the core's decoder and config registers.
- Short commands are 1 byte. Long commands are 5 bytes: an opcode followed by 4 data bytes.

Parameters:
- CLOCK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. BIT_CYCLES = CLOCK_FREQ/BAUD, integer division, must be >= 4.
- TIMEOUT_BITS, 40, idle time in bit periods after which a partial long command is discarded.

Ports:
- clock, input, 1, system clock; all logic is on the rising edge.
- reset_n, input, 1, synchronous, active-low reset.
- rx, input, 1, asynchronous UART receive line, idle high.
- cmd, output, 40, assembled command: [7:0] opcode, [39:8] data.
- execute, output, 1, one-cycle pulse; cmd is valid in the same cycle.
- framingError, output, 1, one-cycle pulse when a byte has a bad stop bit.
- rxActive, output, 1, high while a byte or a partial long command is in progress.

Behaviour:
- Reset (reset_n sampled low on a clock edge): cmd=0, execute=0, framingError=0, rxActive=0. Both FSMs go to idle, counters clear, synchroniser flops load 1. Reset mid-byte or mid-command discards everything received so far.
- rx passes through a 2-flop synchroniser before any use. Synchroniser latency is 2 cycles.
- Bit FSM states and transitions:
  - IDLE: a high-to-low edge on synchronised rx goes to START and loads the bit counter with BIT_CYCLES/2-1.
  - START: at count 0, rx is re-sampled. If high, the edge was a glitch and the FSM returns to IDLE with nothing emitted. If low, it goes to DATA and reloads BIT_CYCLES-1.
  - DATA: 8 samples, one per BIT_CYCLES, LSB first, shifted into the byte register. Then goes to STOP.
  - STOP: one sample. rx=1 raises an internal byteValid for 1 cycle. rx=0 pulses framingError for 1 cycle, the byte is dropped, and the command FSM is forced to OPCODE. In both cases the FSM returns to IDLE in the same cycle, so a new start edge on the next cycle is accepted.
- Command FSM states and transitions:
  - OPCODE: on byteValid, store the opcode. If bit7=0, the command is short: execute fires on the next cycle with cmd={32'h0, opcode}. If bit7=1, go to ARGS with byte index 0.
  - ARGS: each byteValid stores a data byte; index 0 goes to data[7:0], index 3 goes to data[31:24]. On index 3, execute fires on the next cycle with cmd={data, opcode}, and the FSM returns to OPCODE.
- Latency from the stop-bit sample to execute is exactly 1 cycle.
- cmd holds its value after execute until the next command completes. cmd changes only in the execute cycle.
- Timeout: in ARGS, an idle counter runs while the bit FSM is in IDLE and clears on every start edge. When it reaches TIMEOUT_BITS*BIT_CYCLES, the partial command is discarded, the FSM returns to OPCODE, and execute is not asserted.
- Back-to-back commands (stop bit immediately followed by a start bit) are all executed; no byte is lost.
- rxActive = (bit FSM != IDLE) OR (command FSM == ARGS).

Decomposition:
- Shared package: the command-format constants:
  - CMD_WIDTH=40, OPCODE_WIDTH=8.
  - LONG_CMD_BIT=7, LONG_ARG_BYTES=4.
  - Enums for the bit-FSM and command-FSM states.
- One natural sub-module: uart_rx_byte, containing the synchroniser, bit FSM, and baud counter. Its outputs are the byte, byteValid, framingError, and idle.
- Command assembly and the timeout stay in cmd_receiver.

Test Plan:
All scenarios use CLOCK_FREQ=1600, BAUD=100 (BIT_CYCLES=16) and TIMEOUT_BITS=4.
1. Reset: hold reset_n=0 for 3 cycles with rx toggling -> cmd=0, execute=0, rxActive=0 throughout; after release the first clean byte decodes correctly.
2. Short command: send byte 0x01 -> exactly one execute pulse, cmd=40'h00_0000_0001, 1 cycle after the stop-bit sample.
3. Long command: send 0x80, 0x78, 0x56, 0x34, 0x12 back-to-back -> one execute, cmd=40'h12_3456_7880. No execute after the first 4 bytes.
4. Framing error: send 0xC0, then 0x11 with the stop bit forced low -> framingError pulses once, no execute. Then send 0x02 -> execute with cmd=40'h00_0000_0002.
5. Timeout: send 0x81, 0xAA, then idle for 80 cycles, then send 0x00 -> no execute for 0x81; 0x00 executes as a short command, cmd=0.
6. Glitch: rx low for 4 cycles, then high -> no byteValid, no framingError, no execute. Reset mid-way through a long command -> the partial frame is discarded and no execute follows.
